// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: decode-stage load-use stall, taken-branch flush and HALT drain controller
module hazard_detection_unit #(
   parameter int RBITS     = 5,
   parameter int CBITS     = 16,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step_en,
   input  logic [RBITS-1:0] IF_ID_rs,
   input  logic [RBITS-1:0] IF_ID_rt,
   input  logic             IF_ID_uses_rt,
   input  logic [RBITS-1:0] ID_EX_rt,
   input  logic             ID_EX_memread,
   input  logic             branch_taken,
   input  logic             halt_dec,
   output logic             pc_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_bubble,
   output logic             halted,
   output logic [CBITS-1:0] stall_count
);
   localparam int NB = $clog2(DRAIN_CYC + 1);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   state_t state, next_state;
   logic [NB-1:0] cnt, next_cnt;
   logic load_use;
   assign load_use = ID_EX_memread && (ID_EX_rt != '0) &&
                     ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));
   // state, drain counter and halted flag advance only on enabled edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         cnt    <= '0;
         halted <= 1'b0;
      end else if (step_en) begin
         state  <= next_state;
         cnt    <= next_cnt;
         halted <= (next_state == HALTED);
      end
   end
   // saturating count of cycles spent stalled on a load-use hazard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_count <= '0;
      else if (step_en && state == RUN && load_use && stall_count != '1)
         stall_count <= stall_count + 1'b1;
   end
   // next state: a load-use stall defers HALT so ID re-evaluates it next cycle
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         RUN: if (!load_use && halt_dec) begin
            next_state = DRAIN;
            next_cnt   = NB'(DRAIN_CYC);
         end
         DRAIN: begin
            next_cnt = cnt - NB'(1);
            if (cnt == NB'(1)) next_state = HALTED;
         end
         default: ;
      endcase
   end
   // enables are zero in reset and when frozen; otherwise decided by state and hazards
   always_comb begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      if (rst_n && step_en) begin
         case (state)
            RUN: if (load_use) begin
               ID_EX_bubble = 1'b1;
            end else if (!halt_dec) begin
               pc_write    = 1'b1;
               IF_ID_write = 1'b1;
               IF_ID_flush = branch_taken;
            end
            default: ID_EX_bubble = 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: table-driven and scoreboarded checks of the hazard controller
module tb_hazard_detection_unit;
   localparam int CB = 4;
   logic clk = 1'b0, rst_n = 1'b0, step_en = 1'b0;
   logic [4:0] IF_ID_rs = '0, IF_ID_rt = '0, ID_EX_rt = '0;
   logic IF_ID_uses_rt = 1'b0, ID_EX_memread = 1'b0, branch_taken = 1'b0, halt_dec = 1'b0;
   logic pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, halted;
   logic [CB-1:0] stall_count;
   int checks = 0, errors = 0;

   typedef struct {
      logic       step, memread;
      logic [4:0] rs, rt;
      logic       uses_rt;
      logic [4:0] ex_rt;
      logic       br, halt;
      logic [8:0] exp;
   } vec_t;

   logic [8:0] q[$];
   vec_t tbl[10];

   hazard_detection_unit #(.RBITS(5), .CBITS(CB), .DRAIN_CYC(3)) dut (
      .clk(clk), .rst_n(rst_n), .step_en(step_en),
      .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
      .ID_EX_rt(ID_EX_rt), .ID_EX_memread(ID_EX_memread),
      .branch_taken(branch_taken), .halt_dec(halt_dec),
      .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .ID_EX_bubble(ID_EX_bubble), .halted(halted), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic s, logic m, logic [4:0] rs, logic [4:0] rt, logic u,
                               logic [4:0] ert, logic b, logic h, logic [8:0] e);
      vec_t v;
      v.step = s; v.memread = m; v.rs = rs; v.rt = rt; v.uses_rt = u;
      v.ex_rt = ert; v.br = b; v.halt = h; v.exp = e;
      return v;
   endfunction

   function automatic logic [8:0] outs();
      return {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, halted, stall_count};
   endfunction

   task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got pw,iw,fl,bb,hl,cnt=%b expected %b", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      logic [8:0] e;
      @(posedge clk);
      #1;
      step_en = v.step; ID_EX_memread = v.memread; IF_ID_rs = v.rs; IF_ID_rt = v.rt;
      IF_ID_uses_rt = v.uses_rt; ID_EX_rt = v.ex_rt; branch_taken = v.br; halt_dec = v.halt;
      q.push_back(v.exp);
      @(negedge clk);
      if (q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s scoreboard empty", name);
      end else begin
         e = q.pop_front();
         cmp(name, outs(), e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; step_en = 1'b0; halt_dec = 1'b0; branch_taken = 1'b0; ID_EX_memread = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      //              step mr  rs  rt  u  ert br h   pw iw fl bb hl cnt
      tbl[0] = mk(1, 0, 5'd1, 5'd2, 1, 5'd0, 0, 0, 9'b11000_0000);
      tbl[1] = mk(1, 1, 5'd5, 5'd2, 1, 5'd5, 0, 0, 9'b00010_0000);
      tbl[2] = mk(1, 0, 5'd1, 5'd2, 1, 5'd0, 0, 0, 9'b11000_0001);
      tbl[3] = mk(1, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 9'b11000_0001);
      tbl[4] = mk(1, 1, 5'd3, 5'd7, 0, 5'd7, 0, 0, 9'b11000_0001);
      tbl[5] = mk(1, 1, 5'd3, 5'd7, 1, 5'd7, 0, 0, 9'b00010_0001);
      tbl[6] = mk(1, 1, 5'd5, 5'd1, 0, 5'd5, 1, 1, 9'b00010_0010);
      tbl[7] = mk(1, 0, 5'd5, 5'd1, 0, 5'd5, 1, 0, 9'b11100_0011);
      tbl[8] = mk(0, 1, 5'd5, 5'd1, 0, 5'd5, 0, 0, 9'b00000_0011);
      tbl[9] = mk(1, 0, 5'd5, 5'd1, 0, 5'd5, 0, 0, 9'b11000_0011);

      #2;
      cmp("reset_state", outs(), 9'b00000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      cmp("after_release_frozen", outs(), 9'b00000_0000);
      for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

      apply(mk(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 9'b00000_0011), "halt_dec");
      apply(mk(1, 1, 5'd4, 5'd2, 0, 5'd4, 1, 1, 9'b00010_0011), "drain1");
      apply(mk(0, 0, 5'd1, 5'd2, 0, 5'd0, 1, 0, 9'b00000_0011), "drain_frozen1");
      apply(mk(0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 9'b00000_0011), "drain_frozen2");
      apply(mk(1, 0, 5'd1, 5'd2, 0, 5'd0, 1, 0, 9'b00010_0011), "drain2");
      apply(mk(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 9'b00010_0011), "drain3");
      apply(mk(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 9'b00011_0011), "halted1");
      apply(mk(1, 1, 5'd6, 5'd2, 0, 5'd6, 1, 1, 9'b00011_0011), "halted_ignores");
      apply(mk(0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 9'b00001_0011), "halted_frozen");

      do_reset();
      apply(mk(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 9'b00000_0000), "halt_dec2");
      apply(mk(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 9'b00010_0000), "drain_pre_rst");
      @(posedge clk);
      #1;
      cmp("drain_before_async_rst", outs(), 9'b00010_0000);
      rst_n = 1'b0;
      #1;
      cmp("async_rst_in_drain", outs(), 9'b00000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(1, 0, 5'd1, 5'd2, 0, 5'd0, 1, 0, 9'b11100_0000), "run_after_rst");

      do_reset();
      for (int i = 0; i < (1 << CB) + 2; i++)
         apply(mk(1, 1, 5'd9, 5'd2, 0, 5'd9, 0, 0, {5'b00010, CB'(i > 15 ? 15 : i)}),
               $sformatf("sat%0d", i));
      apply(mk(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 9'b11000_1111), "sat_hold");

      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_leftover got %0d entries expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
